// File: rtl/la_pkg.sv
// Shared defaults and state encoding for the logic-analyser capture sequencer.
package la_pkg;

    localparam int LA_ADDR_W = 18;
    localparam int LA_DATA_W = 8;
    localparam int LA_DEPTH  = 2 ** LA_ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } la_state_e;

endpackage

// File: rtl/la_delay_line.sv
// Single-bit shift register of LEN stages; tracks valid through the BRAM read latency.
module la_delay_line #(
    parameter int LEN = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [LEN-1:0] sr_q;
    logic [LEN-1:0] sr_d;

    if (LEN == 1) begin : g_one
        always_comb sr_d = d;
    end else begin : g_many
        always_comb sr_d = {sr_q[LEN-2:0], d};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q[LEN-1];

endmodule

// File: rtl/la_capture_sequencer.sv
// Capture run sequencer: run start/stop, sample counting, and write-priority
// sharing of the single BRAM port between capture engine and host readout.
module la_capture_sequencer
    import la_pkg::*;
#(
    parameter int ADDR_W = LA_ADDR_W,
    parameter int DATA_W = LA_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ctrl_start,
    input  logic              ctrl_abort,
    input  logic [ADDR_W:0]   cfg_max_samples,
    output logic              cap_run,
    input  logic              cap_we,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic [DATA_W-1:0] cap_din,
    input  logic              host_rd_req,
    input  logic [ADDR_W-1:0] host_rd_addr,
    output logic              host_rd_ack,
    output logic              host_rd_valid,
    output logic [DATA_W-1:0] host_rd_data,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              status_busy,
    output logic              status_done,
    output logic              status_aborted,
    output logic              status_stray,
    output logic [ADDR_W:0]   sample_count
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    la_state_e         state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   limit_q, limit_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              stray_q, stray_d;
    logic              bram_en_q, bram_en_d;
    logic              bram_we_q, bram_we_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0] bram_din_q, bram_din_d;
    logic              rd_ack_q, rd_ack_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              run;
    logic              wr_grant;
    logic              rd_grant;
    logic              rd_return;

    // rd_return marks the cycle bram_dout carries data for an acked read
    la_delay_line #(.LEN(RD_LAT)) u_rd_pipe (
        .clk    (clk),
        .resetn (resetn),
        .d      (rd_ack_q),
        .q      (rd_return)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        limit_d   = limit_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        stray_d   = stray_q;

        run      = (state_q == ST_RUN);
        wr_grant = cap_we && run;
        rd_grant = host_rd_req && !wr_grant && !rd_ack_q;

        case (state_q)
            ST_RUN: begin
                if (wr_grant && count_q != DEPTH) begin
                    count_d = count_q + (ADDR_W + 1)'(1);
                end
                if (ctrl_abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else if (wr_grant && count_d == limit_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                if (ctrl_start) begin
                    state_d   = ST_RUN;
                    count_d   = '0;
                    done_d    = 1'b0;
                    aborted_d = 1'b0;
                    stray_d   = 1'b0;
                    if (cfg_max_samples == '0 || cfg_max_samples > DEPTH) begin
                        limit_d = DEPTH;
                    end else begin
                        limit_d = cfg_max_samples;
                    end
                end
            end
        endcase

        if (cap_we && !run) begin
            stray_d = 1'b1;
        end

        bram_en_d   = wr_grant || rd_grant;
        bram_we_d   = wr_grant;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        if (wr_grant) begin
            bram_addr_d = cap_addr;
            bram_din_d  = cap_din;
        end else if (rd_grant) begin
            bram_addr_d = host_rd_addr;
        end
        rd_ack_d = rd_grant;

        rd_valid_d = rd_return;
        rd_data_d  = rd_data_q;
        if (rd_return) begin
            rd_data_d = bram_dout;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            limit_q     <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            stray_q     <= 1'b0;
            bram_en_q   <= 1'b0;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            rd_ack_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            limit_q     <= limit_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            stray_q     <= stray_d;
            bram_en_q   <= bram_en_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
            rd_ack_q    <= rd_ack_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign cap_run        = (state_q == ST_RUN);
    assign status_busy    = (state_q == ST_RUN);
    assign status_done    = done_q;
    assign status_aborted = aborted_q;
    assign status_stray   = stray_q;
    assign sample_count   = count_q;
    assign bram_en        = bram_en_q;
    assign bram_we        = bram_we_q;
    assign bram_addr      = bram_addr_q;
    assign bram_din       = bram_din_q;
    assign host_rd_ack    = rd_ack_q;
    assign host_rd_valid  = rd_valid_q;
    assign host_rd_data   = rd_data_q;

endmodule

// File: tb/tb_la_capture_sequencer.sv
// Directed-plus-random bench for la_capture_sequencer with a behavioural BRAM
// and a shadow memory / read-return queue as the reference.
module tb_la_capture_sequencer;

    localparam int AW     = 4;
    localparam int DW     = 8;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 1 << AW;

    logic          clk = 1'b0;
    logic          resetn;
    logic          ctrl_start, ctrl_abort;
    logic [AW:0]   cfg_max_samples;
    logic          cap_run;
    logic          cap_we;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_din;
    logic          host_rd_req;
    logic [AW-1:0] host_rd_addr;
    logic          host_rd_ack, host_rd_valid;
    logic [DW-1:0] host_rd_data;
    logic          bram_en, bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout;
    logic          status_busy, status_done, status_aborted, status_stray;
    logic [AW:0]   sample_count;

    always #5 clk = ~clk;

    la_capture_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .ctrl_start      (ctrl_start),
        .ctrl_abort      (ctrl_abort),
        .cfg_max_samples (cfg_max_samples),
        .cap_run         (cap_run),
        .cap_we          (cap_we),
        .cap_addr        (cap_addr),
        .cap_din         (cap_din),
        .host_rd_req     (host_rd_req),
        .host_rd_addr    (host_rd_addr),
        .host_rd_ack     (host_rd_ack),
        .host_rd_valid   (host_rd_valid),
        .host_rd_data    (host_rd_data),
        .bram_en         (bram_en),
        .bram_we         (bram_we),
        .bram_addr       (bram_addr),
        .bram_din        (bram_din),
        .bram_dout       (bram_dout),
        .status_busy     (status_busy),
        .status_done     (status_done),
        .status_aborted  (status_aborted),
        .status_stray    (status_stray),
        .sample_count    (sample_count)
    );

    // Behavioural single-port BRAM, one cycle read latency
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_din;
            else         bram_dout <= mem[bram_addr];
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rd_exp_t;

    logic [DW-1:0] shadow [DEPTH];
    rd_exp_t       exp_q[$];
    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_returns();
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            check("rd_valid", 32'(host_rd_valid), 1);
            check("rd_data", 32'(host_rd_data), 32'(exp_q[0].data));
            void'(exp_q.pop_front());
        end else if (host_rd_valid) begin
            check("rd_valid_unexpected", 32'(host_rd_valid), 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check_returns();
    endtask

    function automatic int exp_limit(input int c);
        return (c == 0 || c > DEPTH) ? DEPTH : c;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_cap_run"}, 32'(cap_run), 0);
        check({tag, "_busy"}, 32'(status_busy), 0);
        check({tag, "_done"}, 32'(status_done), 0);
        check({tag, "_aborted"}, 32'(status_aborted), 0);
        check({tag, "_stray"}, 32'(status_stray), 0);
        check({tag, "_count"}, 32'(sample_count), 0);
        check({tag, "_bram_en"}, 32'(bram_en), 0);
        check({tag, "_bram_we"}, 32'(bram_we), 0);
        check({tag, "_bram_addr"}, 32'(bram_addr), 0);
        check({tag, "_bram_din"}, 32'(bram_din), 0);
        check({tag, "_ack"}, 32'(host_rd_ack), 0);
        check({tag, "_valid"}, 32'(host_rd_valid), 0);
        check({tag, "_data"}, 32'(host_rd_data), 0);
    endtask

    task automatic start_run(input int cfg);
        cfg_max_samples = (AW + 1)'(cfg);
        ctrl_start = 1'b1;
        step();
        ctrl_start = 1'b0;
        check("start_cap_run", 32'(cap_run), 1);
        check("start_busy", 32'(status_busy), 1);
        check("start_count", 32'(sample_count), 0);
        check("start_stray_clr", 32'(status_stray), 0);
        check("start_done_clr", 32'(status_done), 0);
        check("start_aborted_clr", 32'(status_aborted), 0);
    endtask

    task automatic write_one(input int a, input int exp_cnt, input bit last);
        logic [DW-1:0] d;
        d = DW'($urandom);
        cap_we = 1'b1; cap_addr = AW'(a); cap_din = d;
        step();
        cap_we = 1'b0;
        check("wr_en", 32'(bram_en), 1);
        check("wr_we", 32'(bram_we), 1);
        check("wr_addr", 32'(bram_addr), 32'(a));
        check("wr_din", 32'(bram_din), 32'(d));
        check("wr_count", 32'(sample_count), 32'(exp_cnt));
        check("wr_cap_run", 32'(cap_run), 32'(!last));
        check("wr_done", 32'(status_done), 32'(last));
        shadow[a] = d;
        repeat (1 + $urandom_range(0, 1)) begin
            step();
            check("gap_idle", 32'(bram_en), 0);
        end
    endtask

    task automatic host_read(input int a, output int ack_cyc);
        bit got = 1'b0;
        ack_cyc = -1;
        host_rd_req = 1'b1; host_rd_addr = AW'(a);
        for (int k = 0; k < 6 && !got; k++) begin
            step();
            if (host_rd_ack) begin
                got = 1'b1;
                ack_cyc = cyc;
            end
        end
        host_rd_req = 1'b0;
        check("rd_ack_seen", 32'(got), 1);
        if (got) exp_q.push_back('{data: shadow[a], due: cyc + RD_LAT + 1});
    endtask

    initial begin
        int lim, ac, prev, a;
        logic [DW-1:0] d;
        resetn = 1'b0; ctrl_start = 1'b0; ctrl_abort = 1'b0; cfg_max_samples = '0;
        cap_we = 1'b0; cap_addr = '0; cap_din = '0; host_rd_req = 1'b0; host_rd_addr = '0;

        repeat (3) step();
        check_zero("reset");
        resetn = 1'b1;
        step();

        // Stray write in IDLE
        cap_we = 1'b1; cap_addr = AW'(9); cap_din = 8'hA5;
        step();
        cap_we = 1'b0;
        check("stray_no_we", 32'(bram_we), 0);
        check("stray_no_en", 32'(bram_en), 0);
        check("stray_flag", 32'(status_stray), 1);
        step();
        check("stray_sticky", 32'(status_stray), 1);

        // cfg 0 means full depth
        start_run(0);
        lim = exp_limit(0);
        for (int i = 0; i < lim; i++) write_one(i, i + 1, (i + 1) == lim);
        check("full_done", 32'(status_done), 1);
        check("full_count", 32'(sample_count), DEPTH);
        check("full_busy", 32'(status_busy), 0);

        // Host burst 0..7 while not running
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            host_read(i, ac);
            if (i > 0) check("burst_ack_spacing", 32'(ac - prev), 2);
            prev = ac;
        end
        repeat (4) step();
        check("burst_drain", 32'(exp_q.size()), 0);

        // Limit 4, config changed after start must not matter
        start_run(4);
        cfg_max_samples = (AW + 1)'(1);
        lim = exp_limit(4);
        for (int i = 0; i < 4; i++) write_one(i, i + 1, (i + 1) == lim);
        check("lim4_count", 32'(sample_count), 4);
        check("lim4_done", 32'(status_done), 1);
        cap_we = 1'b1; cap_addr = AW'(2); cap_din = 8'h3C;
        step();
        cap_we = 1'b0;
        check("done_stray_no_we", 32'(bram_we), 0);
        check("done_stray_flag", 32'(status_stray), 1);
        check("done_count_hold", 32'(sample_count), 4);

        // Write and read requested together, then start+abort together
        start_run(0);
        a = $urandom_range(6, DEPTH - 1);
        d = DW'($urandom);
        cap_we = 1'b1; cap_addr = AW'(a); cap_din = d;
        host_rd_req = 1'b1; host_rd_addr = AW'(5);
        step();
        cap_we = 1'b0;
        shadow[a] = d;
        check("coll_wr_first", 32'(bram_we), 1);
        check("coll_wr_addr", 32'(bram_addr), 32'(a));
        check("coll_no_ack", 32'(host_rd_ack), 0);
        step();
        check("coll_rd_en", 32'(bram_en), 1);
        check("coll_rd_we", 32'(bram_we), 0);
        check("coll_rd_addr", 32'(bram_addr), 5);
        check("coll_ack", 32'(host_rd_ack), 1);
        if (host_rd_ack) exp_q.push_back('{data: shadow[5], due: cyc + RD_LAT + 1});
        host_rd_req = 1'b0;
        ctrl_start = 1'b1; ctrl_abort = 1'b1;
        step();
        ctrl_start = 1'b0; ctrl_abort = 1'b0;
        check("abort_flag", 32'(status_aborted), 1);
        check("abort_not_done", 32'(status_done), 0);
        check("abort_cap_run", 32'(cap_run), 0);
        check("abort_count", 32'(sample_count), 1);
        repeat (3) step();
        check("coll_drain", 32'(exp_q.size()), 0);

        // cfg above depth clamps to depth
        start_run(20);
        lim = exp_limit(20);
        for (int i = 0; i < lim; i++) write_one(i, i + 1, (i + 1) == lim);
        check("clamp_count", 32'(sample_count), DEPTH);

        // Random reads against the shadow memory
        for (int i = 0; i < 10; i++) host_read($urandom_range(0, DEPTH - 1), ac);
        repeat (4) step();
        check("rand_drain", 32'(exp_q.size()), 0);

        // Reset mid-run with a read in flight
        start_run(0);
        write_one(7, 1, 1'b0);
        host_read(3, ac);
        exp_q.delete();
        resetn = 1'b0;
        #1;
        check_zero("reset_mid");
        repeat (3) step();
        resetn = 1'b1;
        repeat (3) step();
        check_zero("post_reset");
        ctrl_abort = 1'b1;
        step();
        ctrl_abort = 1'b0;
        check("idle_abort_ignored", 32'(status_aborted), 0);
        check("idle_abort_busy", 32'(status_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
